uart_cmd_sched: RTL and testbench
=================================

# uart_cmd_sched

Command scheduler between `uart_rx_cmd` and the XINTF-side register bank. It takes each validated UART parameter set (mode, distance, phase offset, exposure time, laser width) and sequences it into eight 16-bit register writes over a req/ack handshake. The last write is a commit word, so the DSP never sees a half-updated parameter set. One command can wait in a pending slot while another is being written.

## Interface
Parameters:
- `TIMEOUT_CYC`, 1023: maximum cycles `wr_req` waits for `wr_ack` before the frame is aborted.
- `ADDR_W`, 4: width of the register-bank word address.

Ports:
- `clk50M` in, 1: system clock, 50 MHz.
- `rst_n` in, 1: asynchronous, active-low reset.
- `cmd_valid` in, 1: one-cycle pulse, parameter inputs valid (driven by `flag_out`).
- `mode` in, 8: operating mode.
- `distance` in, 16: distance in m.
- `phase_diff` in, 32: phase offset in 5 ns units.
- `expose_time` in, 32: exposure time.
- `laser_width` in, 16: laser pulse width.
- `wr_req` out, 1: write request to the register bank.
- `wr_addr` out, `ADDR_W`: word address.
- `wr_data` out, 16: word data.
- `wr_ack` in, 1: the register bank accepted the word.
- `busy` out, 1: a frame is being written.
- `pending` out, 1: the pending slot is occupied.
- `seq_num` out, 8: count of committed frames.
- `drop_cnt` out, 8: number of overwritten pending commands, saturates at 255.
- `bad_mode` out, 1: one-cycle pulse, command rejected for an illegal mode.
- `timeout_err` out, 1: one-cycle pulse, frame aborted on timeout.

## Operation
- **Legal modes:** 0x00, 0x10, 0x20, 0x30, 0x40, 0x50, 0x60, 0x70, 0x80.
  - A `cmd_valid` carrying any other mode is discarded.
  - `bad_mode` pulses on the next cycle.
  - Active frame, pending slot and `drop_cnt` are unaffected.
- **Word order (address: data):**
  - 0: {8'h00, mode}
  - 1: distance
  - 2: phase_diff[15:0]
  - 3: phase_diff[31:16]
  - 4: expose_time[15:0]
  - 5: expose_time[31:16]
  - 6: laser_width
  - 7: commit word {seq_num+1, 8'hA5}
- **States:**
  - IDLE → REQ when a legal command is accepted; word index = 0.
  - REQ: `wr_req`=1, address/data stable. On `wr_ack`: if index = 7, go to IDLE; otherwise go to GAP with index+1.
  - GAP: `wr_req`=0 for exactly one cycle, then REQ.
- **Commit:** on ack of word 7, `seq_num` increments, wrapping 255→0.
- **After a frame ends (commit or abort):** if `pending`=1, the pending entry moves to the active frame in the same cycle, the slot clears and the FSM enters REQ on the next cycle. Otherwise the FSM goes to IDLE.
- **Command arrives while `busy`:**
  - Slot empty: the command is stored.
  - Slot full: the newest command overwrites the slot and `drop_cnt`+1 (saturating).
- **Simultaneous events:**
  - `cmd_valid` in the same cycle the commit ack promotes a full pending slot: the slot takes the new command and no drop is counted.
  - `cmd_valid` in the same cycle the FSM returns to IDLE with an empty slot: the command starts directly.
- **Timeout:** the wait counter resets on every entry to REQ. If it reaches `TIMEOUT_CYC` with no ack:
  - `wr_req` drops and `timeout_err` pulses.
  - The frame is abandoned with no commit write, and `seq_num` is unchanged.
  - The pending slot, if any, then proceeds as above.
- **Parameter latching:** parameters are latched on acceptance. Input changes after `cmd_valid` do not affect a frame in flight.

## Timing
- **Reset values:** every output is 0 (`wr_req`, `wr_addr`, `wr_data`, `busy`, `pending`, `seq_num`, `drop_cnt`, `bad_mode`, `timeout_err`); FSM in IDLE; slot empty.
- **Start latency:** `cmd_valid` at cycle T in IDLE gives `wr_req`=1 with addr 0 at T+1, and `busy`=1 from T+1.
- **Handshake:** `wr_ack` is sampled only while `wr_req`=1. `wr_req` falls the cycle after ack is sampled.
- **Frame length:** with zero-wait ack, one word takes 2 cycles, so a full frame takes 16 cycles from the first `wr_req` to IDLE.
- **Status updates:** `busy` deasserts the cycle after the commit ack, unless a pending entry promotes. `seq_num` updates on that same edge.
- **Reset during a frame:** everything clears immediately and asynchronously; no partial commit is issued.

## Structure
- **Package `u2x_cmd_pkg`:**
  - mode constants (M_NONE … M_STORE)
  - word addresses 0–7
  - commit tag 8'hA5
  - FSM state encoding
  - frame word count (8)
- **Sub-module `cmd_slot`:**
  - one 104-bit parameter register with valid bit
  - load/overwrite/clear controls
  - saturating drop counter
- Used once for the pending slot. The active frame uses a plain register.

## Test plan
- Reset, then mode 0x10, distance 0x1234, phase 0xAABBCCDD, expose 0x00010002, width 0x0050, ack tied high.
  - Writes: 0:0x0010, 1:0x1234, 2:0xCCDD, 3:0xAABB, 4:0x0002, 5:0x0001, 6:0x0050, 7:0x01A5.
  - `seq_num`=1; 16 cycles total.
- Mode 0x35 → `bad_mode` pulse, no `wr_req`, `seq_num` unchanged.
- Three commands A, B, C during frame A, with ack delayed by 5 cycles.
  - C overwrites B, `drop_cnt`=1.
  - Frame C follows A with a 1-cycle handoff; `seq_num`=2.
- `wr_ack` held low, `TIMEOUT_CYC`=20.
  - `timeout_err` one pulse 20 cycles after `wr_req` rises.
  - No address-7 write, `seq_num` unchanged, then IDLE.
- Commit ack coincident with `cmd_valid` while the slot is full: the slot is promoted and refilled, `drop_cnt` unchanged.
- `rst_n` low mid-frame (word 3): all outputs 0 asynchronously; after release, the next command starts at address 0.

Source files
------------

// File: rtl/u2x_cmd_pkg.sv
// Shared definitions for the UART command scheduler: mode codes, register
// word map, commit tag, FSM encoding and the latched parameter set layout.
package u2x_cmd_pkg;

   localparam logic [7:0] M_NONE   = 8'h00;
   localparam logic [7:0] M_SINGLE = 8'h10;
   localparam logic [7:0] M_CONT   = 8'h20;
   localparam logic [7:0] M_GATE   = 8'h30;
   localparam logic [7:0] M_SCAN   = 8'h40;
   localparam logic [7:0] M_TRACK  = 8'h50;
   localparam logic [7:0] M_CALIB  = 8'h60;
   localparam logic [7:0] M_TEST   = 8'h70;
   localparam logic [7:0] M_STORE  = 8'h80;

   localparam logic [2:0] A_MODE   = 3'd0;
   localparam logic [2:0] A_DIST   = 3'd1;
   localparam logic [2:0] A_PH_LO  = 3'd2;
   localparam logic [2:0] A_PH_HI  = 3'd3;
   localparam logic [2:0] A_EXP_LO = 3'd4;
   localparam logic [2:0] A_EXP_HI = 3'd5;
   localparam logic [2:0] A_WIDTH  = 3'd6;
   localparam logic [2:0] A_COMMIT = 3'd7;

   localparam logic [7:0] COMMIT_TAG  = 8'hA5;
   localparam int         FRAME_WORDS = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   typedef struct packed {
      logic [7:0]  mode;
      logic [15:0] distance;
      logic [31:0] phase_diff;
      logic [31:0] expose_time;
      logic [15:0] laser_width;
   } cmd_params_t;

   function automatic logic mode_is_legal(input logic [7:0] m);
      case (m)
         M_NONE, M_SINGLE, M_CONT, M_GATE, M_SCAN,
         M_TRACK, M_CALIB, M_TEST, M_STORE: mode_is_legal = 1'b1;
         default:                           mode_is_legal = 1'b0;
      endcase
   endfunction

   // Data word for a given slot of the frame; the commit word carries the
   // sequence number this frame will receive once acknowledged.
   function automatic logic [15:0] word_data(input cmd_params_t p,
                                             input logic [2:0]  idx,
                                             input logic [7:0]  seq);
      logic [7:0] nxt_seq;
      nxt_seq = seq + 8'd1;
      case (idx)
         A_MODE:   word_data = {8'h00, p.mode};
         A_DIST:   word_data = p.distance;
         A_PH_LO:  word_data = p.phase_diff[15:0];
         A_PH_HI:  word_data = p.phase_diff[31:16];
         A_EXP_LO: word_data = p.expose_time[15:0];
         A_EXP_HI: word_data = p.expose_time[31:16];
         A_WIDTH:  word_data = p.laser_width;
         default:  word_data = {nxt_seq, COMMIT_TAG};
      endcase
   endfunction

endpackage

// File: rtl/uart_cmd_sched_cmd_slot.sv
// Single-entry pending command slot with overwrite accounting.
module cmd_slot
   import u2x_cmd_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_load,
   input  logic        i_clr,
   input  cmd_params_t i_data,
   output cmd_params_t o_data,
   output logic        o_valid,
   output logic [7:0]  o_drop_cnt
);

   cmd_params_t r_data;
   logic        r_valid;
   logic [7:0]  r_drop;

   // Occupancy and drop count; a load into a full slot that is not being drained in the same cycle loses the older command
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_drop  <= 8'd0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         if (r_valid && !i_clr && (r_drop != 8'hFF))
            r_drop <= r_drop + 8'd1;
      end else if (i_clr) begin
         r_valid <= 1'b0;
      end
   end

   // Parameter storage, qualified by r_valid so it needs no reset
   always_ff @(posedge clk) begin
      if (i_load)
         r_data <= i_data;
   end

   assign o_data     = r_data;
   assign o_valid    = r_valid;
   assign o_drop_cnt = r_drop;

endmodule

// File: rtl/uart_cmd_sched.sv
// Sequences each accepted UART parameter set into eight register-bank writes
// over req/ack, ending with a commit word; one further command may wait.
module uart_cmd_sched
   import u2x_cmd_pkg::*;
#(
   parameter int TIMEOUT_CYC = 1023,
   parameter int ADDR_W      = 4
) (
   input  logic              clk50M,
   input  logic              rst_n,
   input  logic              cmd_valid,
   input  logic [7:0]        mode,
   input  logic [15:0]       distance,
   input  logic [31:0]       phase_diff,
   input  logic [31:0]       expose_time,
   input  logic [15:0]       laser_width,
   output logic              wr_req,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [15:0]       wr_data,
   input  logic              wr_ack,
   output logic              busy,
   output logic              pending,
   output logic [7:0]        seq_num,
   output logic [7:0]        drop_cnt,
   output logic              bad_mode,
   output logic              timeout_err
);

   localparam int         WAIT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [2:0] W_LAST = 3'(FRAME_WORDS - 1);

   state_t            r_state, w_state_nxt;
   logic [2:0]        r_idx, w_idx_nxt;
   logic [WAIT_W-1:0] r_wait, w_wait_nxt;
   logic [7:0]        r_seq;
   logic              r_bad, r_tmo;
   cmd_params_t       r_act;
   cmd_params_t       w_cmd, w_slot_data;
   logic              w_slot_vld;
   logic              w_accept, w_ack, w_tmo, w_commit, w_end;
   logic              w_promote, w_start_new, w_slot_load;

   assign w_cmd       = {mode, distance, phase_diff, expose_time, laser_width};
   assign w_accept    = cmd_valid && mode_is_legal(mode);
   assign w_ack       = (r_state == ST_REQ) && wr_ack;
   assign w_tmo       = (r_state == ST_REQ) && !wr_ack &&
                        (r_wait == WAIT_W'(TIMEOUT_CYC - 1));
   assign w_commit    = w_ack && (r_idx == W_LAST);
   assign w_end       = w_commit || w_tmo;
   assign w_promote   = w_end && w_slot_vld;
   // A new command bypasses the slot when nothing is running afterwards
   assign w_start_new = w_accept && ((r_state == ST_IDLE) || (w_end && !w_slot_vld));
   assign w_slot_load = w_accept && !w_start_new;

   cmd_slot u_slot (
      .clk        (clk50M),
      .rst_n      (rst_n),
      .i_load     (w_slot_load),
      .i_clr      (w_promote),
      .i_data     (w_cmd),
      .o_data     (w_slot_data),
      .o_valid    (w_slot_vld),
      .o_drop_cnt (drop_cnt)
   );

   // Control state, commit counter and status pulses
   always_ff @(posedge clk50M or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_idx   <= 3'd0;
         r_wait  <= '0;
         r_seq   <= 8'd0;
         r_bad   <= 1'b0;
         r_tmo   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_wait  <= w_wait_nxt;
         r_bad   <= cmd_valid && !mode_is_legal(mode);
         r_tmo   <= w_tmo;
         if (w_commit)
            r_seq <= r_seq + 8'd1;
      end
   end

   // Active frame parameters: refilled from the pending slot on promotion, otherwise straight from the inputs
   always_ff @(posedge clk50M) begin
      if (w_promote)
         r_act <= w_slot_data;
      else if (w_start_new)
         r_act <= w_cmd;
   end

   // Next-state sequencing and bank-side outputs; address/data are held at zero outside REQ
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_wait_nxt  = r_wait;
      wr_req      = 1'b0;
      busy        = 1'b0;
      wr_addr     = '0;
      wr_data     = 16'h0000;
      case (r_state)
         ST_IDLE: begin
            if (w_start_new) begin
               w_state_nxt = ST_REQ;
               w_idx_nxt   = 3'd0;
               w_wait_nxt  = '0;
            end
         end
         ST_REQ: begin
            wr_req  = 1'b1;
            busy    = 1'b1;
            wr_addr = ADDR_W'(r_idx);
            wr_data = word_data(r_act, r_idx, r_seq);
            if (w_end) begin
               w_idx_nxt   = 3'd0;
               w_wait_nxt  = '0;
               w_state_nxt = (w_promote || w_start_new) ? ST_REQ : ST_IDLE;
            end else if (w_ack) begin
               w_state_nxt = ST_GAP;
               w_idx_nxt   = r_idx + 3'd1;
               w_wait_nxt  = '0;
            end else begin
               w_wait_nxt  = r_wait + WAIT_W'(1);
            end
         end
         ST_GAP: begin
            busy        = 1'b1;
            w_state_nxt = ST_REQ;
            w_wait_nxt  = '0;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign pending     = w_slot_vld;
   assign seq_num     = r_seq;
   assign bad_mode    = r_bad;
   assign timeout_err = r_tmo;

endmodule

// File: tb/tb_uart_cmd_sched.sv
// Directed bench for uart_cmd_sched: frame content, illegal mode, pending
// overwrite, timeout, commit/command collision and mid-frame reset.
module tb_uart_cmd_sched;

   logic        clk50M = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic [7:0]  mode = 8'h00;
   logic [15:0] distance = 16'h0000;
   logic [31:0] phase_diff = 32'h0;
   logic [31:0] expose_time = 32'h0;
   logic [15:0] laser_width = 16'h0000;
   logic        wr_ack = 1'b0;
   logic        wr_req;
   logic [3:0]  wr_addr;
   logic [15:0] wr_data;
   logic        busy, pending, bad_mode, timeout_err;
   logic [7:0]  seq_num, drop_cnt;

   uart_cmd_sched #(.TIMEOUT_CYC(20), .ADDR_W(4)) dut (
      .clk50M(clk50M), .rst_n(rst_n), .cmd_valid(cmd_valid), .mode(mode),
      .distance(distance), .phase_diff(phase_diff), .expose_time(expose_time),
      .laser_width(laser_width), .wr_req(wr_req), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_ack(wr_ack), .busy(busy), .pending(pending),
      .seq_num(seq_num), .drop_cnt(drop_cnt), .bad_mode(bad_mode),
      .timeout_err(timeout_err)
   );

   always #10 clk50M = ~clk50M;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Register-bank model state
   int          cyc = 0, wcnt = 0, ack_dly = 0;
   int          rise_cyc = 0, rise_cnt = 0, tmo_cyc = 0, tmo_cnt = 0, bad_cnt = 0;
   bit          ack_en = 1'b1;
   logic        req_q = 1'b0;
   logic [19:0] log_ad[$];
   int          log_cyc[$];
   int          start_q[$];

   // Bank responder and event recorder, acting on the falling edge
   initial begin
      forever begin
         @(negedge clk50M);
         cyc++;
         if (wr_req && !req_q) begin
            rise_cyc = cyc;
            rise_cnt++;
         end
         if (wr_req && wcnt == 0) start_q.push_back(cyc);
         wr_ack = ack_en && wr_req && (wcnt >= ack_dly);
         if (wr_ack) begin
            log_ad.push_back({wr_addr, wr_data});
            log_cyc.push_back(cyc);
            wcnt = 0;
         end else if (wr_req) wcnt++;
         else wcnt = 0;
         if (timeout_err) begin
            tmo_cnt++;
            tmo_cyc = cyc;
         end
         if (bad_mode) bad_cnt++;
         req_q = wr_req;
      end
   end

   function automatic logic [19:0] get_ad(input int i);
      if (i < log_ad.size()) return log_ad[i];
      return 20'hFFFFF;
   endfunction

   function automatic int get_lcyc(input int i);
      if (i < log_cyc.size()) return log_cyc[i];
      return -1000;
   endfunction

   function automatic int get_start(input int i);
      if (i < start_q.size()) return start_q[i];
      return -1000;
   endfunction

   task automatic sync();
      @(posedge clk50M);
      #2;
   endtask

   // Presents one command for a single cycle starting now, then scrambles the inputs
   task automatic drive_cmd(input logic [7:0] m, input logic [15:0] d, input logic [31:0] p,
                            input logic [31:0] e, input logic [15:0] w);
      mode = m; distance = d; phase_diff = p; expose_time = e; laser_width = w;
      cmd_valid = 1'b1;
      sync();
      cmd_valid   = 1'b0;
      mode        = 8'($urandom);
      distance    = 16'($urandom);
      phase_diff  = $urandom;
      expose_time = $urandom;
      laser_width = 16'($urandom);
   endtask

   task automatic do_reset();
      @(negedge clk50M);
      rst_n = 1'b0;
      ack_en = 1'b1;
      ack_dly = 0;
      repeat (2) @(posedge clk50M);
      #2;
      rst_n = 1'b1;
      log_ad.delete(); log_cyc.delete(); start_q.delete();
      tmo_cnt = 0; bad_cnt = 0; rise_cnt = 0;
   endtask

   // Returns the cycle count from now (counted as 1) through the first idle cycle
   task automatic wait_idle(input string tag, input int maxc, output int n);
      n = 1;
      for (int i = 0; i < maxc; i++) begin
         sync();
         n++;
         if (!busy) break;
      end
      chk(tag, 32'(busy), 32'd0);
   endtask

   task automatic wait_addr(input string tag, input logic [3:0] a);
      for (int i = 0; i < 100; i++) begin
         if (wr_req && wr_addr == a) break;
         sync();
      end
      chk(tag, 32'(wr_req && wr_addr == a), 32'd1);
   endtask

   task automatic chk_all_zero(input string pfx);
      chk({pfx, "_wr_req"},  32'(wr_req), 0);
      chk({pfx, "_wr_addr"}, 32'(wr_addr), 0);
      chk({pfx, "_wr_data"}, 32'(wr_data), 0);
      chk({pfx, "_busy"},    32'(busy), 0);
      chk({pfx, "_pending"}, 32'(pending), 0);
      chk({pfx, "_seq"},     32'(seq_num), 0);
      chk({pfx, "_drop"},    32'(drop_cnt), 0);
      chk({pfx, "_bad"},     32'(bad_mode), 0);
      chk({pfx, "_tmo"},     32'(timeout_err), 0);
   endtask

   logic [19:0] exp1 [8];
   int n;

   initial begin
      exp1 = '{20'h00010, 20'h11234, 20'h2CCDD, 20'h3AABB,
               20'h40002, 20'h50001, 20'h60050, 20'h701A5};

      // Reset state
      repeat (3) @(posedge clk50M);
      #2;
      chk_all_zero("rst");
      rst_n = 1'b1;
      log_ad.delete(); log_cyc.delete(); start_q.delete();

      // Single frame, ack always ready
      sync();
      drive_cmd(8'h10, 16'h1234, 32'hAABBCCDD, 32'h00010002, 16'h0050);
      chk("t1_start_req",  32'(wr_req), 1);
      chk("t1_start_addr", 32'(wr_addr), 0);
      chk("t1_start_busy", 32'(busy), 1);
      wait_idle("t1_done", 60, n);
      chk("t1_frame_len", 32'(n), 16);
      chk("t1_nwords", 32'(log_ad.size()), 8);
      for (int i = 0; i < 8; i++) chk($sformatf("t1_word%0d", i), 32'(get_ad(i)), 32'(exp1[i]));
      chk("t1_seq", 32'(seq_num), 1);

      // Illegal mode
      bad_cnt = 0; rise_cnt = 0;
      sync();
      drive_cmd(8'h35, 16'h1111, 32'h2222, 32'h3333, 16'h4444);
      chk("t2_bad_pulse", 32'(bad_mode), 1);
      sync();
      chk("t2_bad_fall", 32'(bad_mode), 0);
      repeat (4) sync();
      chk("t2_bad_cnt", 32'(bad_cnt), 1);
      chk("t2_no_req", 32'(rise_cnt), 0);
      chk("t2_seq", 32'(seq_num), 1);
      chk("t2_drop", 32'(drop_cnt), 0);

      // A, B, C during frame A with slow ack: C overwrites B
      do_reset();
      ack_dly = 5;
      sync();
      drive_cmd(8'h20, 16'h0A0A, 32'h01020304, 32'h05060708, 16'h0909);
      drive_cmd(8'h30, 16'h0B0B, 32'h11111111, 32'h22222222, 16'h3333);
      chk("t3_pend_b", 32'(pending), 1);
      chk("t3_drop_b", 32'(drop_cnt), 0);
      sync();
      drive_cmd(8'h40, 16'h0C0C, 32'hC0C1C2C3, 32'hC4C5C6C7, 16'h0CC0);
      chk("t3_pend_c", 32'(pending), 1);
      chk("t3_drop_c", 32'(drop_cnt), 1);
      wait_idle("t3_done", 300, n);
      chk("t3_nwords", 32'(log_ad.size()), 16);
      chk("t3_a_commit", 32'(get_ad(7)), 32'h701A5);
      chk("t3_c_mode", 32'(get_ad(8)), 32'h00040);
      chk("t3_c_dist", 32'(get_ad(9)), 32'h10C0C);
      chk("t3_c_phlo", 32'(get_ad(10)), 32'h2C2C3);
      chk("t3_c_commit", 32'(get_ad(15)), 32'h702A5);
      chk("t3_handoff", 32'(get_start(8) - get_lcyc(7)), 1);
      chk("t3_seq", 32'(seq_num), 2);
      chk("t3_pend_end", 32'(pending), 0);

      // Timeout with ack held low
      do_reset();
      ack_en = 1'b0;
      sync();
      drive_cmd(8'h50, 16'h5555, 32'h5, 32'h6, 16'h7);
      repeat (30) sync();
      chk("t4_tmo_cnt", 32'(tmo_cnt), 1);
      chk("t4_tmo_delay", 32'(tmo_cyc - rise_cyc), 20);
      chk("t4_no_write", 32'(log_ad.size()), 0);
      chk("t4_seq", 32'(seq_num), 0);
      chk("t4_idle", 32'(busy), 0);
      chk("t4_req_low", 32'(wr_req), 0);
      ack_en = 1'b1;

      // Commit ack coincides with a new command while the slot holds B
      do_reset();
      sync();
      drive_cmd(8'h60, 16'h6060, 32'h6, 32'h6, 16'h6);
      drive_cmd(8'h70, 16'h7070, 32'h7, 32'h7, 16'h7);
      chk("t5_pend_b", 32'(pending), 1);
      wait_addr("t5_find_commit", 4'd7);
      drive_cmd(8'h80, 16'h8080, 32'h8, 32'h8, 16'h8);
      chk("t5_pend_refill", 32'(pending), 1);
      chk("t5_drop", 32'(drop_cnt), 0);
      chk("t5_seq_a", 32'(seq_num), 1);
      chk("t5_b_req", 32'(wr_req), 1);
      chk("t5_b_addr", 32'(wr_addr), 0);
      chk("t5_b_data", 32'(wr_data), 32'h0070);
      wait_idle("t5_done", 200, n);
      chk("t5_nwords", 32'(log_ad.size()), 24);
      chk("t5_b_commit", 32'(get_ad(15)), 32'h702A5);
      chk("t5_c_mode", 32'(get_ad(16)), 32'h00080);
      chk("t5_c_commit", 32'(get_ad(23)), 32'h703A5);
      chk("t5_seq", 32'(seq_num), 3);
      chk("t5_drop_end", 32'(drop_cnt), 0);

      // Reset asserted during word 3
      do_reset();
      sync();
      drive_cmd(8'h10, 16'h4321, 32'h12345678, 32'h9ABCDEF0, 16'h0101);
      wait_addr("t6_find_w3", 4'd3);
      #1 rst_n = 1'b0;
      #1;
      chk_all_zero("t6");
      chk("t6_partial", 32'(log_ad.size()), 3);
      @(posedge clk50M);
      #2 rst_n = 1'b1;
      log_ad.delete(); log_cyc.delete(); start_q.delete();
      sync();
      drive_cmd(8'h80, 16'h0042, 32'h1, 32'h2, 16'h3);
      chk("t6_restart_addr", 32'(wr_addr), 0);
      chk("t6_restart_data", 32'(wr_data), 32'h0080);
      wait_idle("t6_done", 60, n);
      chk("t6_nwords", 32'(log_ad.size()), 8);
      chk("t6_first", 32'(get_ad(0)), 32'h00080);
      chk("t6_commit", 32'(get_ad(7)), 32'h701A5);
      chk("t6_seq", 32'(seq_num), 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
